// File: rtl/buspirate_top.sv
// Bus Pirate FPGA top: MCU parallel-bus register file, pin-command FIFO, PWM,
// quad-SPI SRAM logic analyser and MCU<->SRAM SPI passthrough.
module buspirate_top #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int LA_WIDTH      = 8,
  parameter int LA_CHIPS      = 2,
  parameter int BP_PINS       = 5,
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  inout  wire  [BP_PINS-1:0]       bpio_io,
  output logic [BP_PINS-1:0]       bpio_dir,
  output logic [BP_PINS-1:0]       bpio_od,
  output logic [LA_CHIPS-1:0]      sram_clock,
  output logic [LA_CHIPS-1:0]      sram_cs,
  inout  wire  [LA_WIDTH-1:0]      sram_sio,
  output logic                     lat_oe,
  input  logic [LA_WIDTH-1:0]      lat,
  input  logic                     mcu_clock,
  input  logic                     mcu_mosi,
  output logic                     mcu_miso,
  input  logic                     mc_oe,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [MC_ADD_WIDTH-1:0] A_SRAM   = MC_ADD_WIDTH'(8'h00);
  localparam logic [MC_ADD_WIDTH-1:0] A_CTRL   = MC_ADD_WIDTH'(8'h02);
  localparam logic [MC_ADD_WIDTH-1:0] A_COUNT  = MC_ADD_WIDTH'(8'h04);
  localparam logic [MC_ADD_WIDTH-1:0] A_PINS   = MC_ADD_WIDTH'(8'h10);
  localparam logic [MC_ADD_WIDTH-1:0] A_PERIOD = MC_ADD_WIDTH'(8'h19);
  localparam logic [MC_ADD_WIDTH-1:0] A_DUTY   = MC_ADD_WIDTH'(8'h1a);

  logic [2:0] we_sync, oe_sync;
  logic       commit_reg, sram_pulse_reg, cs_direct_reg, la_clk_reg, od_reg;
  logic [MC_DATA_WIDTH-1:0] ctrl_reg, la_count_reg, la_cnt_reg, period_reg, duty_reg, pwm_cnt_reg;
  logic [LA_WIDTH-1:0] sram_wdata_reg;
  logic [BP_PINS-1:0]  level_reg, dir_reg;
  logic [FIFO_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] fifo_cnt_reg;

  wire we_fall    = we_sync[2] & ~we_sync[1];
  wire oe_fall    = oe_sync[2] & ~oe_sync[1];
  wire commit     = commit_reg & ~mc_ce;
  wire fifo_empty = (fifo_cnt_reg == '0);
  wire fifo_full  = (fifo_cnt_reg == CW'(FIFO_DEPTH));
  wire push       = commit && (mc_add == A_PINS) && !fifo_full;
  wire pop        = !fifo_empty;
  wire la_active  = ctrl_reg[3];
  wire la_done    = la_active && !la_clk_reg && (la_cnt_reg == la_count_reg);
  wire pass       = ctrl_reg[4] && !la_active;
  wire [MC_DATA_WIDTH-1:0] ctrl_wr = {mc_data[MC_DATA_WIDTH-1:4], ctrl_reg[3] | mc_data[3], mc_data[2:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_sync        <= '0;
      oe_sync        <= '0;
      commit_reg     <= 1'b0;
      sram_pulse_reg <= 1'b0;
    end else begin
      we_sync        <= {we_sync[1:0], mc_we};
      oe_sync        <= {oe_sync[1:0], mc_oe};
      commit_reg     <= we_fall;
      sram_pulse_reg <= (we_fall | oe_fall) && !mc_ce && (mc_add == A_SRAM);
    end
  end

  // Register file and logic-analyser sequencer; a finishing run overrides a same-cycle CTRL write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_reg       <= '0;
      la_count_reg   <= '0;
      la_cnt_reg     <= '0;
      la_clk_reg     <= 1'b0;
      period_reg     <= '0;
      duty_reg       <= '0;
      sram_wdata_reg <= '0;
      cs_direct_reg  <= 1'b0;
    end else begin
      if (commit) begin
        case (mc_add)
          A_SRAM:   sram_wdata_reg <= mc_data[LA_WIDTH-1:0];
          A_CTRL:   begin ctrl_reg <= ctrl_wr; cs_direct_reg <= mc_data[0]; end
          A_COUNT:  la_count_reg <= mc_data;
          A_PERIOD: period_reg <= mc_data;
          A_DUTY:   duty_reg <= mc_data;
          default:  ;
        endcase
      end
      if (la_done) begin
        ctrl_reg[3]   <= 1'b0;
        cs_direct_reg <= 1'b0;
      end
      if (la_active && !la_done) begin
        la_clk_reg <= ~la_clk_reg;
        if (!la_clk_reg) la_cnt_reg <= la_cnt_reg + 1'b1;
      end else begin
        la_clk_reg <= 1'b0;
        la_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= mc_data[FIFO_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      level_reg    <= '0;
      dir_reg      <= '0;
      od_reg       <= 1'b0;
      pwm_cnt_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        level_reg  <= fifo_mem[rd_ptr_reg][BP_PINS-1:0];
        dir_reg    <= fifo_mem[rd_ptr_reg][8 +: BP_PINS];
        od_reg     <= fifo_mem[rd_ptr_reg][FIFO_WIDTH-1];
      end
      fifo_cnt_reg <= fifo_cnt_reg + CW'(push) - CW'(pop);
      if (period_reg == '0 || pwm_cnt_reg >= period_reg) pwm_cnt_reg <= '0;
      else pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  wire pwm_out = (period_reg != '0) && (pwm_cnt_reg < duty_reg);
  logic [BP_PINS-1:0] pin_level;
  always_comb begin
    pin_level = level_reg;
    if (period_reg != '0 && dir_reg[0]) pin_level[0] = pwm_out;
  end

  assign bpio_dir = dir_reg;
  assign bpio_od  = od_reg ? dir_reg : '0;

  // Open-drain pins only ever pull low; a high level releases the line.
  generate
    for (genvar gi = 0; gi < BP_PINS; gi++) begin : g_pin
      assign bpio_io[gi] = (dir_reg[gi] && !(od_reg && pin_level[gi])) ? (pin_level[gi] && !od_reg) : 1'bz;
    end
  endgenerate

  logic [LA_WIDTH-1:0] sio_oe, sio_out;
  always_comb begin
    sio_oe  = '0;
    sio_out = sram_wdata_reg;
    if (la_active) begin
      sio_oe  = '1;
      sio_out = lat;
    end else if (pass) begin
      sio_oe[0]  = 1'b1;
      sio_out[0] = mcu_mosi;
    end else if (ctrl_reg[1]) begin
      sio_oe = '1;
    end
  end

  generate
    for (genvar gi = 0; gi < LA_WIDTH; gi++) begin : g_sio
      assign sram_sio[gi] = sio_oe[gi] ? sio_out[gi] : 1'bz;
    end
  endgenerate

  assign sram_clock = la_active ? {LA_CHIPS{la_clk_reg}} :
                      pass      ? {LA_CHIPS{mcu_clock}}  : {LA_CHIPS{sram_pulse_reg}};
  assign sram_cs    = (la_active || pass) ? '0 : {LA_CHIPS{~cs_direct_reg}};
  assign lat_oe     = ~la_active;
  assign mcu_miso   = pass ? sram_sio[1] : 1'b0;

  logic [MC_DATA_WIDTH-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (mc_add)
      A_SRAM:   rd_data = MC_DATA_WIDTH'(sram_sio);
      A_CTRL:   rd_data = ctrl_reg;
      A_COUNT:  rd_data = la_count_reg;
      A_PINS:   rd_data = MC_DATA_WIDTH'({fifo_full, fifo_empty, 3'b000, bpio_io});
      A_PERIOD: rd_data = period_reg;
      A_DUTY:   rd_data = duty_reg;
      default:  rd_data = '0;
    endcase
  end
  assign mc_data = (!mc_ce && !mc_oe) ? rd_data : 'z;

  wire unused_bits = ^{fifo_mem[rd_ptr_reg][FIFO_WIDTH-2:8+BP_PINS], fifo_mem[rd_ptr_reg][7:BP_PINS]};
endmodule

// File: tb/tb_buspirate_top.sv
// Directed bench for buspirate_top: bus access, pin FIFO, PWM, SRAM direct/LA/passthrough, reset.
module tb_buspirate_top;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  wire  [4:0]  bpio_io;
  logic [4:0]  bpio_dir, bpio_od;
  logic [1:0]  sram_clock, sram_cs;
  wire  [7:0]  sram_sio;
  logic        lat_oe, mcu_miso;
  logic [7:0]  lat = 8'h00;
  logic        mcu_clock = 1'b0, mcu_mosi = 1'b0;
  logic        mc_oe = 1'b1, mc_ce = 1'b1, mc_we = 1'b1;
  logic [5:0]  mc_add = '0;
  wire  [15:0] mc_data;
  logic [15:0] tb_data = '0;
  logic        tb_data_oe = 1'b0;
  logic [7:0]  tb_sio = '0, tb_sio_oe = '0;
  int tests = 0, fails = 0, rises = 0;

  always #5 clock = ~clock;
  always @(posedge sram_clock[0]) rises++;

  assign mc_data = tb_data_oe ? tb_data : 'z;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tb_sio
      assign sram_sio[gi] = tb_sio_oe[gi] ? tb_sio[gi] : 1'bz;
    end
  endgenerate

  buspirate_top dut (
    .clock(clock), .reset(reset), .bpio_io(bpio_io), .bpio_dir(bpio_dir), .bpio_od(bpio_od),
    .sram_clock(sram_clock), .sram_cs(sram_cs), .sram_sio(sram_sio), .lat_oe(lat_oe), .lat(lat),
    .mcu_clock(mcu_clock), .mcu_mosi(mcu_mosi), .mcu_miso(mcu_miso),
    .mc_oe(mc_oe), .mc_ce(mc_ce), .mc_we(mc_we), .mc_add(mc_add), .mc_data(mc_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s got %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    mc_add = a; tb_data = d; tb_data_oe = 1'b1; mc_ce = 1'b0; mc_we = 1'b0;
    repeat (6) @(negedge clock);
    mc_we = 1'b1;
    repeat (2) @(negedge clock);
    mc_ce = 1'b1; tb_data_oe = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clock);
    mc_add = a; mc_ce = 1'b0; mc_oe = 1'b0;
    repeat (4) @(negedge clock);
    d = mc_data;
    mc_oe = 1'b1; mc_ce = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    logic [15:0] rd;
    int base, k, highs;
    logic [3:0] pw;

    // Reset state
    #12;
    check("rst_cs", 32'(sram_cs), 32'h3);
    check("rst_lat_oe", 32'(lat_oe), 32'h1);
    check("rst_sram_clock", 32'(sram_clock), 32'h0);
    check("rst_dir", 32'(bpio_dir), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_miso", 32'(mcu_miso), 32'h0);
    check("rst_od", 32'(bpio_od), 32'h0);
    bus_read(6'h02, rd);
    check("rst_ctrl", 32'(rd), 32'h0);

    // Pin FIFO: each push is popped on the following cycle
    bus_write(6'h10, 16'h0050);
    check("pin_dir_0050", 32'(bpio_dir), 32'h00);
    bus_write(6'h10, 16'h1F0A);
    check("pin_dir_1f0a", 32'(bpio_dir), 32'h1F);
    check("pin_io_1f0a", 32'(bpio_io), 32'h0A);
    check("pin_od_off", 32'(bpio_od), 32'h00);
    bus_read(6'h10, rd);
    check("pin_status", 32'(rd), 32'h010A);
    bus_write(6'h10, 16'h9F0A);
    check("pin_od_on", 32'(bpio_od), 32'h1F);
    check("pin_od_low0", 32'(bpio_io[0]), 32'h0);
    bus_write(6'h10, 16'h1F0A);

    // PWM period 1 duty 1 on bpio[0]
    bus_write(6'h19, 16'h0001);
    bus_write(6'h1a, 16'h0001);
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pw[i] = bpio_io[0];
      highs += int'(bpio_io[0]);
    end
    check("pwm_highs_of_4", 32'(highs), 32'd2);
    check("pwm_alternates", 32'(pw[0] ^ pw[1]), 32'h1);
    bus_write(6'h19, 16'h0000);
    check("pwm_disabled", 32'(bpio_io[0]), 32'h0);

    // SRAM direct mode
    bus_write(6'h04, 16'h0010);
    bus_write(6'h02, 16'h0001);
    check("direct_cs", 32'(sram_cs), 32'h0);
    tb_sio = 8'hAA; tb_sio_oe = 8'hFF;
    base = rises;
    bus_read(6'h00, rd);
    check("sram_rd_aa", 32'(rd), 32'h00AA);
    check("sram_rd_pulse", 32'(rises - base), 32'd1);
    tb_sio = 8'h55;
    bus_read(6'h00, rd);
    check("sram_rd_55", 32'(rd), 32'h0055);
    tb_sio_oe = 8'h00;
    bus_write(6'h02, 16'h0003);
    bus_write(6'h00, 16'h005A);
    check("sram_drive_5a", 32'(sram_sio), 32'h5A);

    // Logic analyser run of 16 samples
    lat = 8'h3C;
    base = rises;
    bus_write(6'h02, 16'h0009);
    check("la_cs_low", 32'(sram_cs), 32'h0);
    check("la_lat_oe_low", 32'(lat_oe), 32'h0);
    check("la_sio_lat", 32'(sram_sio), 32'h3C);
    k = 0;
    while (sram_cs[0] !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("la_done_in_time", 32'(k < 200), 32'h1);
    check("la_rises", 32'(rises - base), 32'd16);
    bus_read(6'h02, rd);
    check("la_ctrl_cleared", 32'(rd), 32'h0001);
    check("la_cs_high", 32'(sram_cs), 32'h3);
    check("la_lat_oe_high", 32'(lat_oe), 32'h1);

    // Zero-length run finishes at once
    bus_write(6'h04, 16'h0000);
    base = rises;
    bus_write(6'h02, 16'h0008);
    bus_read(6'h02, rd);
    check("la0_ctrl", 32'(rd), 32'h0000);
    check("la0_rises", 32'(rises - base), 32'd0);

    // MCU passthrough
    bus_write(6'h02, 16'h0010);
    tb_sio_oe = 8'h02; tb_sio = 8'h02; mcu_mosi = 1'b1; mcu_clock = 1'b1;
    @(negedge clock);
    check("pt_clock_hi", 32'(sram_clock), 32'h3);
    check("pt_mosi_hi", 32'(sram_sio[0]), 32'h1);
    check("pt_miso_hi", 32'(mcu_miso), 32'h1);
    check("pt_cs", 32'(sram_cs), 32'h0);
    tb_sio = 8'h00; mcu_mosi = 1'b0; mcu_clock = 1'b0;
    @(negedge clock);
    check("pt_clock_lo", 32'(sram_clock), 32'h0);
    check("pt_mosi_lo", 32'(sram_sio[0]), 32'h0);
    check("pt_miso_lo", 32'(mcu_miso), 32'h0);
    tb_sio = 8'h02;
    bus_write(6'h02, 16'h0000);
    check("pt_off_miso", 32'(mcu_miso), 32'h0);
    tb_sio_oe = 8'h00;

    // Reset in the middle of a long run
    bus_write(6'h04, 16'h0100);
    bus_write(6'h02, 16'h0008);
    check("rr_running_cs", 32'(sram_cs), 32'h0);
    reset = 1'b0;
    #1;
    check("rr_cs", 32'(sram_cs), 32'h3);
    check("rr_lat_oe", 32'(lat_oe), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    bus_read(6'h02, rd);
    check("rr_ctrl", 32'(rd), 32'h0000);
    bus_read(6'h04, rd);
    check("rr_count", 32'(rd), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
